// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one BCD-to-Gray converter among N_REQ requesters.
// Holds each registered result, with the winner's ID and a non-BCD flag, until the consumer accepts it.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_bcd,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [3:0]            out_gray,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_err,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_out_valid;
    logic [3:0]         r_out_gray;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_err;

    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic               w_accept;
    logic [3:0]         w_sel_bcd;
    logic [N_REQ-1:0]   w_req_ready;

    // The first valid requester at or after rr_ptr (wrapping) wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        w_found = 1'b0;
        w_win   = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // While rst is high, grants are suppressed even though the state already reads IDLE.
    assign w_accept  = !rst && w_found && (r_state == IDLE || out_ready);
    assign w_sel_bcd = req_bcd[4*w_win +: 4];

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = HOLD;
        end else if (r_state == HOLD && out_ready) begin
            w_state_next = IDLE;
        end
    end

    // NOTE: state is updated only with non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_gray  <= '0;
            r_out_id    <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_gray  <= w_sel_bcd ^ (w_sel_bcd >> 1);
                r_out_id    <= w_win;
                r_out_err   <= (w_sel_bcd > 4'd9);
                r_rr_ptr    <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_gray  = r_out_gray;
    assign out_id    = r_out_id;
    assign out_err   = r_out_err;
    assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: a directed vector table, hand-written corner sequences,
// and random traffic checked against a distance-based round-robin reference model.
module tb_gray_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [4*N_REQ-1:0]   req_bcd;
    logic [N_REQ-1:0]     req_ready;
    logic                 out_valid;
    logic [3:0]           out_gray;
    logic [ID_W-1:0]      out_id;
    logic                 out_err;
    logic                 out_ready;
    logic                 busy;

    int n_checks;
    int n_errors;

    gray_conv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bcd   (req_bcd),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_id    (out_id),
        .out_err   (out_err),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held-result record plus a priority pointer.
    logic [3:0] gray_tab [16];
    int         m_ptr;
    bit         m_valid;
    logic [3:0] m_gray;
    int         m_id;
    bit         m_err;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] bcd;
        logic        ordy;
        logic [3:0]  ready;
        logic        valid;
        logic [3:0]  gray;
        int          id;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_gray  = 4'd0;
        m_id    = 0;
        m_err   = 1'b0;
    endtask

    // Winner = valid requester with the smallest circular distance from the pointer.
    function automatic int model_winner(input logic [N_REQ-1:0] rv);
        int best_d;
        int win;
        best_d = N_REQ;
        win    = -1;
        for (int i = 0; i < N_REQ; i++) begin
            if (rv[i]) begin
                int d;
                d = (i - m_ptr + N_REQ) % N_REQ;
                if (d < best_d) begin
                    best_d = d;
                    win    = i;
                end
            end
        end
        return win;
    endfunction

    // Called at posedge+1: drive, check grant at negedge, check registers after the edge.
    task automatic apply(input logic [N_REQ-1:0] rv, input logic [4*N_REQ-1:0] bcd, input logic ordy,
                         input logic [N_REQ-1:0] e_ready, input logic e_valid, input logic [3:0] e_gray,
                         input int e_id, input logic e_err, input string tag);
        req_valid = rv;
        req_bcd   = bcd;
        out_ready = ordy;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'(e_ready));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, " busy"},      32'(busy),      32'(e_valid));
        check({tag, " out_gray"},  32'(out_gray),  32'(e_gray));
        check({tag, " out_id"},    32'(out_id),    32'(e_id));
        check({tag, " out_err"},   32'(out_err),   32'(e_err));
    endtask

    task automatic model_cycle(input logic [N_REQ-1:0] rv, input logic [4*N_REQ-1:0] bcd,
                               input logic ordy, input string tag);
        int               w;
        bit               acc;
        logic [N_REQ-1:0] er;
        logic [3:0]       digit;
        w   = model_winner(rv);
        acc = (w >= 0) && (!m_valid || ordy);
        er  = '0;
        if (acc) begin
            er[w]   = 1'b1;
            digit   = bcd[4*w +: 4];
            m_gray  = gray_tab[digit];
            m_id    = w;
            m_err   = (int'(digit) > 9);
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N_REQ;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        apply(rv, bcd, ordy, er, m_valid, m_gray, m_id, m_err, tag);
    endtask

    // Holds rst across two edges with every requester asking, checking the reset outputs.
    task automatic do_reset();
        req_valid = 4'b1111;
        req_bcd   = 16'h1234;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset out_gray",  32'(out_gray),  32'd0);
        check("reset out_id",    32'(out_id),    32'd0);
        check("reset out_err",   32'(out_err),   32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_bcd   = '0;
        out_ready = 1'b0;
        gray_tab  = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                      4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        model_reset();

        // Directed table: rotation 1,3,9,5; non-BCD 12; idle; grant from IDLE; stall; drain.
        vecs[0]  = '{4'b1111, 16'h5931, 1'b1, 4'b0001, 1'b1, 4'b0001, 0, 1'b0};
        vecs[1]  = '{4'b1111, 16'h5931, 1'b1, 4'b0010, 1'b1, 4'b0010, 1, 1'b0};
        vecs[2]  = '{4'b1111, 16'h5931, 1'b1, 4'b0100, 1'b1, 4'b1101, 2, 1'b0};
        vecs[3]  = '{4'b1111, 16'h5931, 1'b1, 4'b1000, 1'b1, 4'b0111, 3, 1'b0};
        vecs[4]  = '{4'b0100, 16'h0C00, 1'b1, 4'b0100, 1'b1, 4'b1010, 2, 1'b1};
        vecs[5]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b1010, 2, 1'b1};
        vecs[6]  = '{4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'b0111, 0, 1'b0};
        vecs[7]  = '{4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b1, 4'b0111, 0, 1'b0};
        vecs[8]  = '{4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b1, 4'b0111, 0, 1'b0};
        vecs[9]  = '{4'b0010, 16'h0070, 1'b1, 4'b0010, 1'b1, 4'b0100, 1, 1'b0};
        vecs[10] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'b0100, 1, 1'b0};
        vecs[11] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rv, vecs[i].bcd, vecs[i].ordy, vecs[i].ready, vecs[i].valid,
                  vecs[i].gray, vecs[i].id, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Single digit after reset: 5 -> 0111 from requester 0.
        do_reset();
        model_cycle(4'b0001, 16'h0005, 1'b1, "first");

        // Stall five cycles with requester 1 waiting, then release.
        for (int i = 0; i < 5; i++) begin
            model_cycle(4'b0010, 16'h0080, 1'b0, $sformatf("stall%0d", i));
        end
        model_cycle(4'b0010, 16'h0080, 1'b1, "release");

        // Only requester 3 asking: granted every cycle across the pointer wrap.
        for (int i = 0; i < 6; i++) begin
            model_cycle(4'b1000, 16'h2000 * 16'(i % 8), 1'b1, $sformatf("solo3_%0d", i));
        end

        // Asynchronous reset while a result is held.
        model_cycle(4'b0001, 16'h0003, 1'b0, "pre_rst");
        req_valid = 4'b0110;
        req_bcd   = 16'h0440;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst busy",      32'(busy),      32'd0);
        check("async rst req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("held rst req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        model_reset();
        model_cycle(4'b0110, 16'h0440, 1'b1, "post_rst");
        check("post_rst lowest id", 32'(out_id), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [N_REQ-1:0]   rv;
            logic [4*N_REQ-1:0] bcd;
            logic               ordy;
            rv   = N_REQ'($urandom);
            bcd  = (4*N_REQ)'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            model_cycle(rv, bcd, ordy, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
